gru_seq_ctrl: RTL and testbench
===============================

GRU_SEQ_CTRL -- requirements
Module: gru_seq_ctrl

Interface
REQ-001 SHALL have parameter FIXED, default 32, datapath word width in bits.
REQ-002 SHALL have parameter M, default 24, input vector length.
REQ-003 SHALL have parameter N, default 24, neuron count; weight row stride is 3*N.
REQ-004 SHALL have parameter AW, default 16, address width.
REQ-005 SHALL have the following ports; one clock; reset synchronous, active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin one GRU timestep.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse, timestep complete.
- phase  out  2  0=Z, 1=R, 2=H.
- b_addr  out  AW  bias address.
- w_addr  out  AW  input/recurrent weight address.
- in_idx  out  AW  operand index into input or state vector.
- mac_clr  out  1  load accumulator with bias.
- mac_en  out  1  accumulate one product.
- mac_sel  out  1  0=input weights/vector, 1=recurrent weights/state.
- mac_rmul  out  1  multiply recurrent product by r[in_idx].
- act_req  out  1  request activation of accumulator (sigmoid Z/R, tanh H).
- act_ack  in  1  activation result valid.
- wb_en  out  1  write activation result.
- wb_idx  out  AW  neuron index j of write-back.

Function
REQ-010 SHALL use states IDLE, BIAS, MAC_IN, MAC_REC, ACT, WB, FIN.
REQ-011 IDLE->BIAS when start=1; start while busy SHALL be ignored.
REQ-012 BIAS: one cycle, mac_clr=1, b_addr=phase*N+j.
REQ-013 MAC_IN: M cycles, i=0..M-1, mac_en=1, mac_sel=0, in_idx=i, w_addr=i*3N+phase*N+j.
REQ-014 MAC_REC: N cycles, i=0..N-1, mac_en=1, mac_sel=1, same address formula; mac_rmul=1 only when phase=H.
REQ-015 ACT: act_req=1, held until act_ack=1, no timeout; ack in the first ACT cycle costs one cycle.
REQ-016 WB: one cycle, wb_en=1, wb_idx=j. Next: j<N-1 -> j+1, BIAS. j=N-1 and phase<H -> j=0, phase+1, BIAS. Otherwise -> FIN.
REQ-017 FIN: done=1 for one cycle, then IDLE; start in the FIN cycle SHALL be ignored.
REQ-018 busy=1 in every state except IDLE.
REQ-019 Strobes mac_clr, mac_en, act_req, wb_en, done SHALL be mutually exclusive.
REQ-020 Per-neuron latency with immediate ack SHALL be M+N+3 cycles. Start sampled at cycle k gives done at k+1+3N(M+N+3).
REQ-021 Address arithmetic SHALL be unsigned, computed at AW bits. Parameters SHALL satisfy 3N*max(M,N) < 2^AW.
REQ-022 Outputs SHALL be registered; addresses valid in the same cycle as their strobe.

Reset
REQ-030 rst=1 SHALL force IDLE in the next cycle, from any state, including mid-MAC and mid-ACT.
REQ-031 After reset: all outputs 0; i, j, phase counters 0.
REQ-032 An aborted sequence SHALL not produce done or wb_en.

Configuration
REQ-040 With GRU_SEQ_CTRL_PERF_EN defined: add output cyc_cnt (32 bits). It clears on the start-accept cycle, increments each busy cycle, holds after FIN, resets to 0.
REQ-041 Without GRU_SEQ_CTRL_PERF_EN: port cyc_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-050 Shared package gru_pkg SHALL hold FIXED, the phase encoding (PH_Z, PH_R, PH_H) and the state enum.
REQ-051 Address generation SHALL be a sub-module gru_addr_gen (inputs phase, i, j; outputs b_addr, w_addr); the FSM and counters stay in gru_seq_ctrl.

Verification
REQ-060 M=N=24, act_ack tied 1, start at cycle 10 -> done pulse at cycle 3683; exactly 72 wb_en pulses, wb_idx 0..23 three times.
REQ-061 phase=R, j=2, MAC_IN i=3 -> w_addr=242, b_addr during BIAS=26.
REQ-062 act_ack delayed 5 cycles per neuron -> act_req held 6 cycles each; done delayed by 72*5 cycles vs REQ-060.
REQ-063 rst asserted during MAC_REC of phase H, j=7 -> IDLE next cycle, all outputs 0, no done; a new start runs a full sequence.
REQ-064 start pulsed during busy and during the FIN cycle -> ignored; exactly one done per accepted start.
REQ-065 mac_rmul=1 only in MAC_REC with phase=H; count = 24*24 = 576 cycles.

Source files
------------

// File: rtl/gru_pkg.sv
// Shared definitions for the GRU timestep sequencer: datapath word width,
// phase encoding (Z, R, H gates) and the sequencer state enumeration.
package gru_pkg;

    localparam int FIXED = 32;

    localparam logic [1:0] PH_Z = 2'd0;
    localparam logic [1:0] PH_R = 2'd1;
    localparam logic [1:0] PH_H = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC_IN,
        MAC_REC,
        ACT,
        WB,
        FIN
    } state_t;

endpackage

// File: rtl/gru_addr_gen.sv
// Bias and weight address generator for the GRU sequencer.
// Ports: phase, i (operand index), j (neuron index) in;
//        b_addr = phase*N + j, w_addr = i*3N + phase*N + j out.
// All arithmetic is unsigned and truncated to AW bits.
module gru_addr_gen
    import gru_pkg::*;
#(
    parameter int N  = 24,
    parameter int AW = 16
) (
    input  logic [1:0]    phase,
    input  logic [AW-1:0] i,
    input  logic [AW-1:0] j,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] w_addr
);

    localparam logic [AW-1:0] STRIDE = AW'(3 * N);
    localparam logic [AW-1:0] NN     = AW'(N);

    logic [AW-1:0] ph_ext;
    logic [AW-1:0] gate_off;

    assign ph_ext   = {{(AW-2){1'b0}}, phase};
    assign gate_off = ph_ext * NN + j;
    assign b_addr   = gate_off;
    assign w_addr   = i * STRIDE + gate_off;

endmodule

// File: rtl/gru_seq_ctrl.sv
// GRU timestep sequencer: for each phase Z, R, H and each neuron j it loads
// the bias, accumulates M input and N recurrent products, requests an
// activation and writes the result back, then pulses done.
// Ports: clk, rst (sync, active-high), start, act_ack in; busy, done, phase,
//        b_addr, w_addr, in_idx, mac_clr, mac_en, mac_sel, mac_rmul,
//        act_req, wb_en, wb_idx out (all registered).
// Optional: GRU_SEQ_CTRL_PERF_EN adds cyc_cnt, a 32-bit busy-cycle counter.
module gru_seq_ctrl
    import gru_pkg::*;
#(
    parameter int FIXED = gru_pkg::FIXED,
    parameter int M     = 24,
    parameter int N     = 24,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    phase,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] in_idx,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          mac_sel,
    output logic          mac_rmul,
    output logic          act_req,
    input  logic          act_ack,
    output logic          wb_en,
    output logic [AW-1:0] wb_idx
`ifdef GRU_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]   cyc_cnt
`endif
);

    localparam longint unsigned MAXMN = (M > N) ? M : N;

    // Reject configurations whose addresses would wrap at AW bits.
    if (FIXED < 1 || longint'(3 * N) * MAXMN >= (64'd1 << AW)) begin : g_bad_params
        $error("gru_seq_ctrl: parameters violate 3N*max(M,N) < 2^AW");
    end

    localparam logic [AW-1:0] M_LAST = AW'(M - 1);
    localparam logic [AW-1:0] N_LAST = AW'(N - 1);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] i;
    logic [AW-1:0] i_n;
    logic [AW-1:0] j;
    logic [AW-1:0] j_n;
    logic [1:0]    ph;
    logic [1:0]    ph_n;
    logic [AW-1:0] b_addr_n;
    logic [AW-1:0] w_addr_n;

    // Next-state and next-counter values; the registered outputs below are
    // derived from these so every strobe lines up with its address.
    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        ph_n    = ph;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = BIAS;
                    i_n     = '0;
                    j_n     = '0;
                    ph_n    = PH_Z;
                end
            end
            BIAS: begin
                state_n = MAC_IN;
                i_n     = '0;
            end
            MAC_IN: begin
                if (i == M_LAST) begin
                    state_n = MAC_REC;
                    i_n     = '0;
                end else begin
                    i_n = i + AW'(1);
                end
            end
            MAC_REC: begin
                if (i == N_LAST) begin
                    state_n = ACT;
                    i_n     = '0;
                end else begin
                    i_n = i + AW'(1);
                end
            end
            ACT: begin
                if (act_ack) begin
                    state_n = WB;
                end
            end
            WB: begin
                if (j != N_LAST) begin
                    state_n = BIAS;
                    j_n     = j + AW'(1);
                end else if (ph != PH_H) begin
                    state_n = BIAS;
                    j_n     = '0;
                    ph_n    = ph + 2'd1;
                end else begin
                    state_n = FIN;
                    j_n     = '0;
                    ph_n    = PH_Z;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    gru_addr_gen #(
        .N  (N),
        .AW (AW)
    ) u_addr_gen (
        .phase  (ph_n),
        .i      (i_n),
        .j      (j_n),
        .b_addr (b_addr_n),
        .w_addr (w_addr_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            ph       <= PH_Z;
            busy     <= 1'b0;
            done     <= 1'b0;
            phase    <= 2'd0;
            b_addr   <= '0;
            w_addr   <= '0;
            in_idx   <= '0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_sel  <= 1'b0;
            mac_rmul <= 1'b0;
            act_req  <= 1'b0;
            wb_en    <= 1'b0;
            wb_idx   <= '0;
        end else begin
            state    <= state_n;
            i        <= i_n;
            j        <= j_n;
            ph       <= ph_n;
            busy     <= (state_n != IDLE);
            done     <= (state_n == FIN);
            phase    <= ph_n;
            b_addr   <= (state_n == BIAS) ? b_addr_n : '0;
            mac_clr  <= (state_n == BIAS);
            act_req  <= (state_n == ACT);
            wb_en    <= (state_n == WB);
            wb_idx   <= (state_n == WB) ? j_n : '0;
            if (state_n == MAC_IN || state_n == MAC_REC) begin
                w_addr <= w_addr_n;
                in_idx <= i_n;
                mac_en <= 1'b1;
            end else begin
                w_addr <= '0;
                in_idx <= '0;
                mac_en <= 1'b0;
            end
            mac_sel  <= (state_n == MAC_REC);
            // Only the candidate (H) gate scales the recurrent term by r.
            mac_rmul <= (state_n == MAC_REC) && (ph_n == PH_H);
        end
    end

`ifdef GRU_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (state == IDLE && start) begin
            cyc_cnt <= '0;
        end else if (busy) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed testbench for gru_seq_ctrl (M=N=24, AW=16).
// Scenario tasks run in sequence; a negedge monitor gathers pulse statistics.
module tb_gru_seq_ctrl;

    localparam int M  = 24;
    localparam int N  = 24;
    localparam int AW = 16;
    localparam int LAT = 1 + 3 * N * (M + N + 3);

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [1:0]    phase;
    logic [AW-1:0] b_addr;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] in_idx;
    logic          mac_clr;
    logic          mac_en;
    logic          mac_sel;
    logic          mac_rmul;
    logic          act_req;
    logic          act_ack;
    logic          wb_en;
    logic [AW-1:0] wb_idx;
`ifdef GRU_SEQ_CTRL_PERF_EN
    logic [31:0]   cyc_cnt;
`endif

    gru_seq_ctrl #(
        .M  (M),
        .N  (N),
        .AW (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .phase    (phase),
        .b_addr   (b_addr),
        .w_addr   (w_addr),
        .in_idx   (in_idx),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .mac_sel  (mac_sel),
        .mac_rmul (mac_rmul),
        .act_req  (act_req),
        .act_ack  (act_ack),
        .wb_en    (wb_en),
        .wb_idx   (wb_idx)
`ifdef GRU_SEQ_CTRL_PERF_EN
        ,
        .cyc_cnt  (cyc_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activation unit model: ack arrives after ack_delay cycles of act_req.
    int ack_delay = 0;
    int ack_cnt = 0;
    assign act_ack = act_req && (ack_cnt == ack_delay);
    always @(posedge clk) begin
        if (act_req && !act_ack) ack_cnt <= ack_cnt + 1;
        else ack_cnt <= 0;
    end

    int pass = 0;
    int total = 0;

    int done_cnt, done_cyc, wb_cnt, wb_err, rmul_cnt, rmul_err, excl_err;
    int act_run, act_min, act_max;

    always @(negedge clk) begin
        if ($countones({mac_clr, mac_en, act_req, wb_en, done}) > 1)
            excl_err++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wb_en) begin
            if (int'(wb_idx) != wb_cnt % N) wb_err++;
            wb_cnt++;
        end
        if (mac_rmul) begin
            rmul_cnt++;
            if (!(mac_en && mac_sel && phase == 2'd2)) rmul_err++;
        end
        if (act_req) begin
            act_run++;
        end else if (act_run > 0) begin
            if (act_run < act_min) act_min = act_run;
            if (act_run > act_max) act_max = act_run;
            act_run = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        done_cnt = 0;
        done_cyc = 0;
        wb_cnt   = 0;
        wb_err   = 0;
        rmul_cnt = 0;
        rmul_err = 0;
        excl_err = 0;
        act_run  = 0;
        act_min  = 1000000;
        act_max  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_seq(output int s);
        clr_mon();
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (done_cnt != 0) pass++;
        else $display("FAIL %s: no done within %0d cycles", nm, budget);
    endtask

    task automatic test_reset();
        logic [5*AW+12:0] outs;
        do_reset();
        outs = {busy, done, phase, b_addr, w_addr, in_idx, mac_clr, mac_en,
                mac_sel, mac_rmul, act_req, wb_en, wb_idx};
        total++;
        if (outs !== '0) $display("FAIL reset_outs: got %h want 0", outs);
        else pass++;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass++;
    endtask

    task automatic test_full_seq();
        int s;
        start_seq(s);
        wait_done(5000, "full_done");
        total++;
        if (done_cyc - s !== LAT)
            $display("FAIL full_latency: got %0d want %0d", done_cyc - s, LAT);
        else pass++;
        repeat (3) tick();
        total++;
        if (wb_cnt !== 3 * N) $display("FAIL full_wb_cnt: got %0d want %0d", wb_cnt, 3 * N);
        else pass++;
        total++;
        if (wb_err !== 0) $display("FAIL full_wb_idx: got %0d errors want 0", wb_err);
        else pass++;
        total++;
        if (rmul_cnt !== N * N) $display("FAIL rmul_cnt: got %0d want %0d", rmul_cnt, N * N);
        else pass++;
        total++;
        if (rmul_err !== 0) $display("FAIL rmul_ctx: got %0d errors want 0", rmul_err);
        else pass++;
        total++;
        if (excl_err !== 0) $display("FAIL strobe_excl: got %0d errors want 0", excl_err);
        else pass++;
        total++;
        if (done_cnt !== 1) $display("FAIL full_done_cnt: got %0d want 1", done_cnt);
        else pass++;
        total++;
        if (busy !== 1'b0) $display("FAIL full_idle: busy got %b want 0", busy);
        else pass++;
    endtask

    task automatic test_addr();
        int s;
        int n = 0;
        start_seq(s);
        while (!(mac_clr && wb_cnt == N + 2) && n < 3000) begin
            tick();
            n++;
        end
        total++;
        if (b_addr !== 16'd26 || phase !== 2'd1)
            $display("FAIL bias_addr: got %0d ph %0d want 26 ph 1", b_addr, phase);
        else pass++;
        repeat (4) tick();
        total++;
        if (w_addr !== 16'd242) $display("FAIL win_addr: got %0d want 242", w_addr);
        else pass++;
        total++;
        if (in_idx !== 16'd3 || mac_sel !== 1'b0)
            $display("FAIL win_idx: got %0d sel %b want 3 sel 0", in_idx, mac_sel);
        else pass++;
        repeat (M - 3) tick();
        total++;
        if (mac_sel !== 1'b1 || mac_rmul !== 1'b0 || in_idx !== 16'd0)
            $display("FAIL rec_ctl: sel %b rmul %b idx %0d want 1 0 0", mac_sel, mac_rmul, in_idx);
        else pass++;
        total++;
        if (w_addr !== 16'd26) $display("FAIL rec_addr: got %0d want 26", w_addr);
        else pass++;
        do_reset();
    endtask

    task automatic test_ack_delay();
        int s;
        ack_delay = 5;
        start_seq(s);
        wait_done(6000, "ack_done");
        repeat (3) tick();
        total++;
        if (done_cyc - s !== LAT + 3 * N * 5)
            $display("FAIL ack_latency: got %0d want %0d", done_cyc - s, LAT + 3 * N * 5);
        else pass++;
        total++;
        if (act_min !== 6 || act_max !== 6)
            $display("FAIL act_hold: got min %0d max %0d want 6", act_min, act_max);
        else pass++;
        total++;
        if (wb_cnt !== 3 * N) $display("FAIL ack_wb_cnt: got %0d want %0d", wb_cnt, 3 * N);
        else pass++;
        ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        int s;
        int n = 0;
        logic [5*AW+12:0] outs;
        start_seq(s);
        while (!(mac_sel && phase == 2'd2 && in_idx == 16'd5 && wb_cnt == 2 * N + 7)
               && n < 4000) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outs = {busy, done, phase, b_addr, w_addr, in_idx, mac_clr, mac_en,
                mac_sel, mac_rmul, act_req, wb_en, wb_idx};
        total++;
        if (outs !== '0 || n >= 4000)
            $display("FAIL abort_outs: got %h want 0 (search %0d)", outs, n);
        else pass++;
        repeat (20) tick();
        total++;
        if (done_cnt !== 0 || wb_cnt !== 2 * N + 7)
            $display("FAIL abort_quiet: done %0d wb %0d want 0 %0d", done_cnt, wb_cnt, 2 * N + 7);
        else pass++;
        start_seq(s);
        wait_done(5000, "rerun_done");
        repeat (3) tick();
        total++;
        if (done_cyc - s !== LAT || wb_cnt !== 3 * N)
            $display("FAIL rerun: lat %0d wb %0d want %0d %0d", done_cyc - s, wb_cnt, LAT, 3 * N);
        else pass++;
    endtask

    task automatic test_ignored_start();
        int s;
        start_seq(s);
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(5000, "ign_done");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        total++;
        if (done_cnt !== 1) $display("FAIL ign_done_cnt: got %0d want 1", done_cnt);
        else pass++;
        total++;
        if (busy !== 1'b0) $display("FAIL ign_busy: got %b want 0", busy);
        else pass++;
        total++;
        if (done_cyc - s !== LAT)
            $display("FAIL ign_latency: got %0d want %0d", done_cyc - s, LAT);
        else pass++;
    endtask

    task automatic test_back_to_back();
        int s;
        start_seq(s);
        wait_done(5000, "b2b_done1");
        tick();
        start_seq(s);
        wait_done(5000, "b2b_done2");
        total++;
        if (done_cyc - s !== LAT)
            $display("FAIL b2b_latency: got %0d want %0d", done_cyc - s, LAT);
        else pass++;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clr_mon();
        test_reset();
        test_full_seq();
        test_addr();
        test_ack_delay();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
